// File: rtl/load_store_unit.sv
// Load/store unit: takes one memory request from execute, drives a word-aligned
// memory handshake, and returns a sign/zero-extended load result or a fault.
module load_store_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

    state_t            state;
    state_t            state_next;
    logic              req_ok;
    logic              size_ok;
    logic              req_is_load;
    logic [2:0]        req_funct3;
    logic [1:0]        req_offset;
    logic [DATA_W-1:0] wdata_new;
    logic [3:0]        wstrb_new;
    logic [DATA_W-1:0] rdata_shifted;
    logic [DATA_W-1:0] load_extracted;

    // Unsigned sizes only exist for loads; H needs even, W needs word alignment.
    always_comb begin
        size_ok = 1'b0;
        case (funct3)
            3'b000:  size_ok = 1'b1;
            3'b001:  size_ok = !addr[0];
            3'b010:  size_ok = (addr[1:0] == 2'b00);
            3'b100:  size_ok = mem_read;
            3'b101:  size_ok = mem_read && !addr[0];
            default: size_ok = 1'b0;
        endcase
        req_ok = (mem_read ^ mem_write) && size_ok;
    end

    always_comb begin
        wdata_new = '0;
        wstrb_new = 4'b0000;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    wdata_new = {4{store_data[7:0]}};
                    wstrb_new = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    wdata_new = {2{store_data[15:0]}};
                    wstrb_new = 4'b0011 << addr[1:0];
                end
                default: begin
                    wdata_new = store_data;
                    wstrb_new = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        rdata_shifted = mem_rdata >> {req_offset, 3'b000};
        case (req_funct3)
            3'b000:  load_extracted = {{(DATA_W-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_extracted = {{(DATA_W-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_extracted = {{(DATA_W-8){1'b0}}, rdata_shifted[7:0]};
            3'b101:  load_extracted = {{(DATA_W-16){1'b0}}, rdata_shifted[15:0]};
            default: load_extracted = mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = req_ok ? ACCESS : FAULT;
            ACCESS:  if (mem_ready) state_next = RESP;
            RESP:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Request fields freeze at acceptance so the bus stays stable while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_is_load <= 1'b0;
            req_funct3  <= 3'b000;
            req_offset  <= 2'b00;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= 4'b0000;
            load_data   <= '0;
        end else begin
            if (state == IDLE && start && req_ok) begin
                req_is_load <= mem_read;
                req_funct3  <= funct3;
                req_offset  <= addr[1:0];
                mem_we      <= mem_write;
                mem_addr    <= {addr[DATA_W-1:2], 2'b00};
                mem_wdata   <= wdata_new;
                mem_wstrb   <= wstrb_new;
            end
            if (state == ACCESS && mem_ready && req_is_load)
                load_data <= load_extracted;
        end
    end

    assign busy    = (state != IDLE);
    assign mem_req = (state == ACCESS);
    assign done    = (state == RESP) || (state == FAULT);
    assign fault   = (state == FAULT);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// requests compared against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int          compare_count  = 0;
    int          mismatch_count = 0;
    logic [31:0] model_load_data = 32'h0;

    load_store_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr),
        .store_data(store_data), .busy(busy), .done(done), .fault(fault),
        .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] a);
        bit ok;
        if (rd == wr) return 1'b0;
        case (f3)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (a % 2 == 0);
            3'd2:    ok = (a % 4 == 0);
            3'd4:    ok = rd;
            3'd5:    ok = rd && (a % 2 == 0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] w;
        w = rdata >> (8 * (a % 4));
        case (f3)
            3'd0:    return ((w & 32'hFF) >= 32'h80) ? (w & 32'hFF) - 32'h100 : (w & 32'hFF);
            3'd1:    return ((w & 32'hFFFF) >= 32'h8000) ? (w & 32'hFFFF) - 32'h10000 : (w & 32'hFFFF);
            3'd4:    return w & 32'hFF;
            3'd5:    return w & 32'hFFFF;
            default: return rdata;
        endcase
    endfunction

    task automatic randomize_request_fields();
        mem_read   = 1'($urandom);
        mem_write  = 1'($urandom);
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
    endtask

    // Issues one request and checks every cycle until the unit is back in IDLE.
    // Entered and left at a negedge with the unit idle.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rdata, input int waits, input bit hammer);
        bit          legal;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        legal = model_legal(rd, wr, f3, a);
        exp_wdata = sd;
        exp_wstrb = 4'hF;
        if (f3[1:0] == 2'd0) begin
            exp_wdata = (sd & 32'hFF) * 32'h01010101;
            exp_wstrb = 4'(1 << (a % 4));
        end else if (f3[1:0] == 2'd1) begin
            exp_wdata = (sd & 32'hFFFF) * 32'h00010001;
            exp_wstrb = 4'(3 << (a % 4));
        end
        if (rd) exp_wstrb = 4'h0;

        start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        mem_ready = 1'b0;
        @(negedge clk);
        if (!legal) begin
            checkOutput("fault_done", 32'(done), 32'd1);
            checkOutput("fault_flag", 32'(fault), 32'd1);
            checkOutput("fault_no_req", 32'(mem_req), 32'd0);
            checkOutput("fault_load_hold", load_data, model_load_data);
            start = hammer;
        end else begin
            for (int i = 0; i <= waits; i++) begin
                checkOutput("acc_req", 32'(mem_req), 32'd1);
                checkOutput("acc_busy", 32'(busy), 32'd1);
                checkOutput("acc_no_done", 32'(done), 32'd0);
                checkOutput("acc_addr", mem_addr, a & 32'hFFFF_FFFC);
                checkOutput("acc_we", 32'(mem_we), 32'(wr));
                checkOutput("acc_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                if (wr) checkOutput("acc_wdata", mem_wdata, exp_wdata);
                if (hammer) begin
                    randomize_request_fields();
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                mem_ready = (i == waits);
                mem_rdata = (i == waits) ? rdata : $urandom;
                @(negedge clk);
            end
            mem_ready = 1'b0;
            if (rd) model_load_data = model_load(f3, a, rdata);
            checkOutput("resp_done", 32'(done), 32'd1);
            checkOutput("resp_fault", 32'(fault), 32'd0);
            checkOutput("resp_no_req", 32'(mem_req), 32'd0);
            checkOutput("resp_load", load_data, model_load_data);
            start = hammer;
        end
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_req", 32'(mem_req), 32'd0);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        addr = 32'h0; store_data = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_addr", mem_addr, 32'h0);
        checkOutput("rst_wdata", mem_wdata, 32'h0);
        checkOutput("rst_wstrb", 32'(mem_wstrb), 32'h0);
        checkOutput("rst_load", load_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1, 0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 2, 0);
        checkOutput("lw_result", load_data, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 3'b000, 32'h0000_2003, 32'h0, 32'h8011_2233, 0, 0);
        checkOutput("lb_result", load_data, 32'hFFFF_FF80);
        applyStimulus(1, 0, 3'b100, 32'h0000_2003, 32'h0, 32'h8011_2233, 0, 0);
        checkOutput("lbu_result", load_data, 32'h0000_0080);
        applyStimulus(0, 1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h5555_5555, 0, 0);
        checkOutput("sh_load_hold", load_data, 32'h0000_0080);
        applyStimulus(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
        applyStimulus(1, 0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
        applyStimulus(1, 1, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
        applyStimulus(1, 0, 3'b101, 32'h0000_0302, 32'h0, 32'h7FFF_1234, 3, 1);

        // Reset in the middle of a waited access, with ready and start both asserted.
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0040;
        @(negedge clk);
        start = 1'b0;
        checkOutput("prerst_req", 32'(mem_req), 32'd1);
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D; start = 1'b1;
        @(negedge clk);
        model_load_data = 32'h0;
        rst = 1'b0; mem_ready = 1'b0; start = 1'b0;
        checkOutput("midrst_req", 32'(mem_req), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_load", load_data, 32'h0);
        @(negedge clk);
        checkOutput("postrst_busy", 32'(busy), 32'd0);
        checkOutput("postrst_done", 32'(done), 32'd0);
        applyStimulus(1, 0, 3'b010, 32'h0000_0040, 32'h0, 32'h0BAD_CAFE, 1, 0);

        for (int n = 0; n < 300; n++) begin
            bit          rd;
            bit          wr;
            logic [2:0]  f3;
            logic [31:0] a;
            int          kind;
            kind = int'($urandom_range(0, 9));
            rd   = (kind < 5) ? 1'b1 : (kind < 9) ? 1'b0 : 1'($urandom);
            wr   = (kind < 5) ? 1'b0 : (kind < 9) ? 1'b1 : 1'($urandom);
            f3   = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (rd && $urandom_range(0, 2) == 0) f3 = f3 | 3'b100;
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((f3[1:0] == 2'd2) ? 32'h3 : (f3[1:0] == 2'd1) ? 32'h1 : 32'h0);
            applyStimulus(rd, wr, f3, a, $urandom, $urandom,
                          int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DATA_W, 32, data and address width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request valid from execute, sampled only in IDLE.
REQ-005 Port: mem_read  input  1  request is a load.
REQ-006 Port: mem_write  input  1  request is a store.
REQ-007 Port: funct3  input  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 Port: addr  input  32  byte address, i.e. the ALU result.
REQ-009 Port: store_data  input  32  rs2 value for stores.
REQ-010 Port: busy  output  1  high in any state other than IDLE.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: fault  output  1  valid with done; misaligned or illegal request.
REQ-013 Port: load_data  output  32  extended load result; holds until the next done.
REQ-014 Port: mem_req  output  1  memory request, held until accepted.
REQ-015 Port: mem_we  output  1  high for a store.
REQ-016 Port: mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-017 Port: mem_wdata  output  32  store data replicated across byte lanes.
REQ-018 Port: mem_wstrb  output  4  byte-lane write enables; 0000 for loads.
REQ-019 Port: mem_ready  input  1  memory accepts/completes the request this cycle.
REQ-020 Port: mem_rdata  input  32  read word, valid when mem_ready=1 on a load.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS, RESP and FAULT.
REQ-022 IDLE: start=1 with exactly one of mem_read or mem_write, a legal funct3 and aligned addr -> ACCESS; all request fields are latched on that edge.
REQ-023 IDLE: start=1 with both or neither of mem_read/mem_write, an illegal funct3 (011, 11x; or 1xx on a store), or misalignment (H/HU addr[0]=1; W addr[1:0]!=0) -> FAULT, and no mem_req is issued.
REQ-024 ACCESS: mem_req=1, and mem_we, mem_addr, mem_wdata and mem_wstrb SHALL stay constant; mem_ready=1 -> RESP, otherwise stay in ACCESS with no timeout.
REQ-025 RESP: done=1 and fault=0 for one cycle, load_data updated on the preceding edge for loads, then -> IDLE.
REQ-026 FAULT: done=1 and fault=1 for one cycle, load_data unchanged, then -> IDLE.
REQ-027 Latency: start at cycle T -> mem_req at T+1; with mem_ready at T+1+k, done at T+2+k; fault done at T+1.
REQ-028 start while busy=1 SHALL be ignored, with no queuing; a new start SHALL be accepted in the cycle after done, once back in IDLE.
REQ-029 Store lanes: B -> wdata {4{sd[7:0]}}, wstrb 0001<<addr[1:0]; H -> wdata {2{sd[15:0]}}, wstrb 0011<<addr[1:0]; W -> wdata sd, wstrb 1111.
REQ-030 Load extraction: the byte/half is selected by the latched addr[1:0] from mem_rdata; B/H are sign-extended, BU/HU are zero-extended, and W passes through.
REQ-031 mem_req SHALL be combinationally independent of start, which guarantees at least one registered cycle.
REQ-032 mem_rdata SHALL be ignored on stores, and load_data SHALL be unchanged by stores.

Reset
REQ-033 While rst=1 at a rising edge: state -> IDLE; busy, done, fault, mem_req, mem_we = 0; mem_addr, mem_wdata, load_data = 0; mem_wstrb = 0000.
REQ-034 rst=1 during ACCESS SHALL drop mem_req on the next cycle with no done pulse; a mem_ready in the same cycle as rst SHALL be discarded.
REQ-035 start coincident with rst SHALL be ignored.

Verification
REQ-036 LW addr 0x1000, mem_ready after 2 wait cycles, rdata 0xDEADBEEF -> mem_req held 3 cycles, mem_addr 0x1000, done at T+4, load_data 0xDEADBEEF.
REQ-037 LB addr 0x2003, rdata 0x80112233, ready immediately -> load_data 0xFFFFFF80; the same access with LBU -> 0x00000080; done at T+2.
REQ-038 SH addr 0x0102, store_data 0x1234ABCD -> mem_addr 0x0100, mem_wdata 0xABCDABCD, mem_wstrb 1100, mem_we=1, done with fault=0.
REQ-039 LW addr 0x0101 -> no mem_req, done=1 and fault=1 at T+1, load_data unchanged; funct3=011 load -> same response.
REQ-040 rst pulse during ACCESS with mem_ready=0 -> mem_req=0 the next cycle, busy=0, no done; a subsequent LW completes normally.
REQ-041 start re-asserted every cycle during a waited access -> exactly one mem_req transaction and one done; the next start after done is accepted.
